// File: rtl/pc_unit_ras.sv
// Program-counter unit with stall, relative branch, indirect jump and a circular
// return-address stack for call/return. Drives the instruction-memory address.
module pc_unit_ras #(
  parameter int WORD_SIZE   = 16,
  parameter int TARGET_BITS = 12,
  parameter int RAS_DEPTH   = 4,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           jump,
  input  logic [TARGET_BITS-1:0]         jump_target,
  input  logic                           jump_reg,
  input  logic [WORD_SIZE-1:0]           reg_target,
  input  logic                           branch_taken,
  input  logic [WORD_SIZE-1:0]           branch_offset,
  input  logic                           call,
  input  logic                           ret,
  output logic [WORD_SIZE-1:0]           inst_addr,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [WORD_SIZE-1:0] PC_ONE     = WORD_SIZE'(1);
  localparam logic [PTR_W-1:0]     PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]     FULL_COUNT = CNT_W'(RAS_DEPTH);

  logic [WORD_SIZE-1:0] stack [RAS_DEPTH];
  logic [PTR_W-1:0]     top_ptr;
  logic [PTR_W-1:0]     pop_ptr;
  logic [WORD_SIZE-1:0] pc_plus_one;
  logic [WORD_SIZE-1:0] next_pc;
  logic                 ras_empty;
  logic                 ras_full;
  logic                 do_push;

  // top_ptr names the slot the next push writes; when full that slot holds the oldest entry.
  assign pop_ptr     = top_ptr - PTR_ONE;
  assign pc_plus_one = inst_addr + PC_ONE;
  assign ras_empty   = (ras_count == '0);
  assign ras_full    = (ras_count == FULL_COUNT);
  assign do_push     = call & (jump | jump_reg) & ~ret;

  always_comb begin
    next_pc = pc_plus_one;
    if (ret) begin
      next_pc = ras_empty ? reg_target : stack[pop_ptr];
    end else if (jump_reg) begin
      next_pc = reg_target;
    end else if (jump) begin
      next_pc = {inst_addr[WORD_SIZE-1:TARGET_BITS], jump_target};
    end else if (branch_taken) begin
      next_pc = pc_plus_one + branch_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_addr     <= RESET_VECTOR;
      ras_count     <= '0;
      top_ptr       <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (!stall) begin
      inst_addr <= next_pc;
      if (ret) begin
        if (ras_empty) begin
          ras_underflow <= 1'b1;
        end else begin
          ras_count <= ras_count - CNT_ONE;
          top_ptr   <= pop_ptr;
        end
      end else if (do_push) begin
        top_ptr <= top_ptr + PTR_ONE;
        if (ras_full) begin
          ras_overflow <= 1'b1;
        end else begin
          ras_count <= ras_count + CNT_ONE;
        end
      end
    end
  end

  // Stack storage needs no reset: entries are only read while ras_count marks them valid.
  always_ff @(posedge clk) begin
    if (!reset && !stall && do_push) begin
      stack[top_ptr] <= pc_plus_one;
    end
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_pc_unit_ras;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        jump;
  logic [11:0] jump_target;
  logic        jump_reg;
  logic [15:0] reg_target;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        call;
  logic        ret;
  logic [15:0] inst_addr;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model state: the stack is a plain queue, newest entry at the back.
  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  logic        m_ovf;
  logic        m_unf;

  pc_unit_ras #(
    .WORD_SIZE(16), .TARGET_BITS(12), .RAS_DEPTH(4), .RESET_VECTOR(16'h0000)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .jump_target(jump_target),
    .jump_reg(jump_reg), .reg_target(reg_target), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .call(call), .ret(ret), .inst_addr(inst_addr),
    .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    chk_cnt++;
    if (observed !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelStep();
    int t;
    logic [15:0] push_val;
    if (reset) begin
      m_pc = 16'h0000;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!stall) begin
      if (ret) begin
        if (m_stack.size() == 0) begin
          m_pc  = reg_target;
          m_unf = 1'b1;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end else begin
        push_val = 16'(int'(m_pc) + 1);
        if (jump_reg) m_pc = reg_target;
        else if (jump) m_pc = (m_pc & 16'hF000) | {4'h0, jump_target};
        else if (branch_taken) begin
          t = int'(m_pc) + 1 + int'($signed(branch_offset));
          m_pc = 16'(t);
        end else m_pc = 16'(int'(m_pc) + 1);
        if (call && (jump || jump_reg)) begin
          m_stack.push_back(push_val);
          if (m_stack.size() > 4) begin
            void'(m_stack.pop_front());
            m_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, then sample just after the edge.
  task automatic applyStimulus(input logic rst, input logic st, input logic rt, input logic jr,
                               input logic jp, input logic [11:0] jt, input logic [15:0] rtgt,
                               input logic br, input logic [15:0] off, input logic cl);
    reset = rst; stall = st; ret = rt; jump_reg = jr; jump = jp; jump_target = jt;
    reg_target = rtgt; branch_taken = br; branch_offset = off; call = cl;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("inst_addr", 32'(inst_addr), 32'(m_pc));
    checkOutput("ras_count", 32'(ras_count), 32'(m_stack.size()));
    checkOutput("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
    checkOutput("ras_underflow", 32'(ras_underflow), 32'(m_unf));
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 12'h0, 16'h0, 0, 16'h0, 0);
  endtask

  task automatic setPc(input logic [15:0] pc);
    applyStimulus(0, 0, 0, 1, 0, 12'h0, pc, 0, 16'h0, 0);
  endtask

  initial begin
    m_pc = 16'h0; m_ovf = 1'b0; m_unf = 1'b0;
    reset = 1; stall = 0; jump = 0; jump_target = '0; jump_reg = 0; reg_target = '0;
    branch_taken = 0; branch_offset = '0; call = 0; ret = 0;

    // Reset for two edges, then free-run
    applyStimulus(1, 0, 0, 0, 0, 12'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("t1_reset_pc0", 32'(inst_addr), 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 12'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("t1_reset_pc1", 32'(inst_addr), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      idle();
      checkOutput("t1_freerun", 32'(inst_addr), 32'(i));
    end

    // Pseudo-direct jump keeps upper PC bits; increment wraps
    setPc(16'h5FFE);
    applyStimulus(0, 0, 0, 0, 1, 12'h123, 16'h0, 0, 16'h0, 0);
    checkOutput("t2_jump", 32'(inst_addr), 32'h5123);
    setPc(16'hFFFF);
    idle();
    checkOutput("t2_wrap", 32'(inst_addr), 32'h0);

    // Branch with negative offset, then the same under stall
    setPc(16'h0010);
    applyStimulus(0, 0, 0, 0, 0, 12'h0, 16'h0, 1, 16'hFFFD, 0);
    checkOutput("t3_branch", 32'(inst_addr), 32'h000E);
    setPc(16'h0010);
    applyStimulus(0, 1, 0, 0, 0, 12'h0, 16'h0, 1, 16'hFFFD, 0);
    checkOutput("t3_stall", 32'(inst_addr), 32'h0010);

    // Call and return
    setPc(16'h0040);
    applyStimulus(0, 0, 0, 0, 1, 12'h200, 16'h0, 0, 16'h0, 1);
    checkOutput("t4_call_pc", 32'(inst_addr), 32'h0200);
    checkOutput("t4_call_cnt", 32'(ras_count), 32'd1);
    applyStimulus(0, 0, 1, 0, 0, 12'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("t4_ret_pc", 32'(inst_addr), 32'h0041);
    checkOutput("t4_ret_cnt", 32'(ras_count), 32'd0);

    // Overflow overwrites the oldest, then drain and underflow
    setPc(16'h0001);
    for (int i = 1; i <= 5; i++)
      applyStimulus(0, 0, 0, 0, 1, 12'(i + 1), 16'h0, 0, 16'h0, 1);
    checkOutput("t5_full_cnt", 32'(ras_count), 32'd4);
    checkOutput("t5_overflow", 32'(ras_overflow), 32'd1);
    for (int i = 6; i >= 3; i--) begin
      applyStimulus(0, 0, 1, 0, 0, 12'h0, 16'h0, 0, 16'h0, 0);
      checkOutput("t5_pop", 32'(inst_addr), 32'(i));
    end
    applyStimulus(0, 0, 1, 0, 0, 12'h0, 16'h0777, 0, 16'h0, 0);
    checkOutput("t5_underflow_pc", 32'(inst_addr), 32'h0777);
    checkOutput("t5_underflow", 32'(ras_underflow), 32'd1);

    // ret+call+jump pops only; reset discards a nonempty stack
    applyStimulus(1, 0, 0, 0, 0, 12'h0, 16'h0, 0, 16'h0, 0);
    applyStimulus(0, 0, 0, 0, 1, 12'h010, 16'h0, 0, 16'h0, 1);
    applyStimulus(0, 0, 1, 0, 1, 12'h030, 16'h0, 0, 16'h0, 1);
    checkOutput("t6_pop_only_pc", 32'(inst_addr), 32'h0001);
    checkOutput("t6_pop_only_cnt", 32'(ras_count), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 12'h010, 16'h0, 0, 16'h0, 1);
    applyStimulus(0, 0, 0, 1, 0, 12'h0, 16'h1234, 0, 16'h0, 1);
    applyStimulus(1, 0, 0, 0, 0, 12'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("t6_reset_cnt", 32'(ras_count), 32'd0);
    checkOutput("t6_reset_pc", 32'(inst_addr), 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 3) == 0), 12'($urandom), 16'($urandom),
                    ($urandom_range(0, 3) == 0), 16'($urandom_range(0, 15)) - 16'd8,
                    ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
